// File: rtl/fft4_input_framer.sv
// Serial-to-parallel input stage for the 4-point FFT core: collects four complex
// samples per frame, loads them into registered outputs and produces latency-matched strobes.
module fft4_input_framer #(
  parameter int DW         = 16,
  parameter int CORE_LAT   = 2,
  parameter bit CHECK_LAST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  input  logic          s_last,
  input  logic          err_clr,
  output logic [DW-1:0] x0_re,
  output logic [DW-1:0] x0_im,
  output logic [DW-1:0] x1_re,
  output logic [DW-1:0] x1_im,
  output logic [DW-1:0] x2_re,
  output logic [DW-1:0] x2_im,
  output logic [DW-1:0] x3_re,
  output logic [DW-1:0] x3_im,
  output logic          frame_valid,
  output logic          fft_valid,
  output logic [15:0]   frame_cnt,
  output logic          err_sticky
);

  logic [1:0]          idx;
  logic [DW-1:0]       h0_re, h0_im, h1_re, h1_im, h2_re, h2_im;
  logic [CORE_LAT-1:0] fv_dly;
  logic                beat;
  logic                new_err;

  assign beat = s_valid && s_ready;

  // A framing error is s_last on the wrong beat: early on beats 0..2, missing on beat 3.
  always_comb begin
    new_err = 1'b0;
    if (beat && CHECK_LAST)
      new_err = (idx == 2'd3) ? !s_last : s_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready     <= 1'b0;
      idx         <= 2'd0;
      h0_re       <= '0;
      h0_im       <= '0;
      h1_re       <= '0;
      h1_im       <= '0;
      h2_re       <= '0;
      h2_im       <= '0;
      x0_re       <= '0;
      x0_im       <= '0;
      x1_re       <= '0;
      x1_im       <= '0;
      x2_re       <= '0;
      x2_im       <= '0;
      x3_re       <= '0;
      x3_im       <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= 16'd0;
      err_sticky  <= 1'b0;
      fv_dly      <= '0;
    end else begin
      s_ready     <= 1'b1;
      frame_valid <= 1'b0;
      if (beat) begin
        if (idx == 2'd3) begin
          // The fourth sample bypasses the hold registers so the whole frame loads in one edge.
          x0_re       <= h0_re;
          x0_im       <= h0_im;
          x1_re       <= h1_re;
          x1_im       <= h1_im;
          x2_re       <= h2_re;
          x2_im       <= h2_im;
          x3_re       <= s_re;
          x3_im       <= s_im;
          frame_valid <= 1'b1;
          frame_cnt   <= frame_cnt + 16'd1;
          idx         <= 2'd0;
        end else begin
          case (idx)
            2'd0:    begin h0_re <= s_re; h0_im <= s_im; end
            2'd1:    begin h1_re <= s_re; h1_im <= s_im; end
            default: begin h2_re <= s_re; h2_im <= s_im; end
          endcase
          idx <= (CHECK_LAST && s_last) ? 2'd0 : idx + 2'd1;
        end
      end
      if (new_err)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
      fv_dly[0] <= frame_valid;
      for (int i = 1; i < CORE_LAT; i++)
        fv_dly[i] <= fv_dly[i-1];
    end
  end

  assign fft_valid = fv_dly[CORE_LAT-1];

endmodule

// File: tb/tb_fft4_input_framer.sv
// Self-checking bench for fft4_input_framer: random sample streams compared against a
// queue-based frame model, plus directed framing-error and reset scenarios.
module tb_fft4_input_framer;
  localparam int DW = 16;
  localparam int L  = 2;

  typedef struct {
    bit            v;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    bit            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] s_re = '0;
  logic [DW-1:0] s_im = '0;
  logic          s_ready, frame_valid, fft_valid, err_sticky;
  logic [15:0]   frame_cnt;
  logic [DW-1:0] xo [8];
  logic          d0_ready, d0_fv, d0_fft, d0_err;
  logic [15:0]   d0_cnt;
  logic [DW-1:0] d0_x [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft4_input_framer #(.DW(DW), .CORE_LAT(L), .CHECK_LAST(1'b1)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im), .s_last(s_last), .err_clr(err_clr),
    .x0_re(xo[0]), .x0_im(xo[1]), .x1_re(xo[2]), .x1_im(xo[3]),
    .x2_re(xo[4]), .x2_im(xo[5]), .x3_re(xo[6]), .x3_im(xo[7]),
    .frame_valid(frame_valid), .fft_valid(fft_valid),
    .frame_cnt(frame_cnt), .err_sticky(err_sticky)
  );

  fft4_input_framer #(.DW(DW), .CORE_LAT(L), .CHECK_LAST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(d0_ready),
    .s_re(s_re), .s_im(s_im), .s_last(s_last), .err_clr(err_clr),
    .x0_re(d0_x[0]), .x0_im(d0_x[1]), .x1_re(d0_x[2]), .x1_im(d0_x[3]),
    .x2_re(d0_x[4]), .x2_im(d0_x[5]), .x3_re(d0_x[6]), .x3_im(d0_x[7]),
    .frame_valid(d0_fv), .fft_valid(d0_fft),
    .frame_cnt(d0_cnt), .err_sticky(d0_err)
  );

  // Reference model: accepted samples collect in a queue; a frame is emitted when four
  // have arrived, and each emission time is remembered to predict the delayed strobe.
  int                cyc = 0;
  int                last_reset = 0;
  bit                emit [int];
  logic [2*DW-1:0]   part [$];
  logic [DW-1:0]     exp_x [8];
  bit                exp_fv, exp_fft, m_ready, exp_err, m_newerr;
  logic [15:0]       exp_cnt, exp_cnt0;
  int                n0;

  always @(posedge clk) begin
    cyc++;
    exp_fv = 1'b0;
    if (reset) begin
      m_ready = 1'b0;
      part.delete();
      for (int k = 0; k < 8; k++) exp_x[k] = '0;
      exp_cnt = '0;
      exp_err = 1'b0;
      last_reset = cyc;
      n0 = 0;
      exp_cnt0 = '0;
    end else begin
      m_newerr = 1'b0;
      if (s_valid && m_ready) begin
        part.push_back({s_re, s_im});
        n0++;
        if (n0 == 4) begin
          n0 = 0;
          exp_cnt0++;
        end
        if (part.size() == 4) begin
          for (int k = 0; k < 4; k++) begin
            exp_x[2*k]   = part[k][2*DW-1:DW];
            exp_x[2*k+1] = part[k][DW-1:0];
          end
          exp_fv = 1'b1;
          exp_cnt++;
          emit[cyc] = 1'b1;
          m_newerr = !s_last;
          part.delete();
        end else if (s_last) begin
          m_newerr = 1'b1;
          part.delete();
        end
      end
      if (m_newerr) exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
      m_ready = 1'b1;
    end
    exp_fft = emit.exists(cyc - L) && (last_reset <= cyc - L);
  end

  beat_t stim [$];
  beat_t last_frame [$];

  function automatic logic [19:0] dut_st();
    return {frame_valid, fft_valid, s_ready, err_sticky, frame_cnt};
  endfunction

  function automatic logic [19:0] mdl_st();
    return {exp_fv, exp_fft, m_ready, exp_err, exp_cnt};
  endfunction

  function automatic logic [8*DW-1:0] dut_x();
    logic [8*DW-1:0] r;
    for (int k = 0; k < 8; k++) r[(7-k)*DW +: DW] = xo[k];
    return r;
  endfunction

  function automatic logic [8*DW-1:0] mdl_x();
    logic [8*DW-1:0] r;
    for (int k = 0; k < 8; k++) r[(7-k)*DW +: DW] = exp_x[k];
    return r;
  endfunction

  // Expected parallel word built straight from the most recently generated frame stimulus.
  function automatic logic [8*DW-1:0] stim_x();
    logic [8*DW-1:0] r;
    for (int k = 0; k < 4; k++) begin
      r[(7-2*k)*DW +: DW] = last_frame[k].re;
      r[(6-2*k)*DW +: DW] = last_frame[k].im;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input beat_t b);
    s_valid = b.v;
    s_re    = b.re;
    s_im    = b.im;
    s_last  = b.last;
  endtask

  task automatic add_idle(input int n);
    beat_t b;
    b = '{v: 1'b0, re: '0, im: '0, last: 1'b0};
    repeat (n) stim.push_back(b);
  endtask

  task automatic add_frame(input bit mark_last, input int gap);
    beat_t b;
    last_frame.delete();
    for (int k = 0; k < 4; k++) begin
      b = '{v: 1'b1, re: DW'($urandom), im: DW'($urandom), last: mark_last && (k == 3)};
      stim.push_back(b);
      last_frame.push_back(b);
      if (k < 3) add_idle(gap);
    end
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    err_clr = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    tick();
    stim.delete();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1;
      s_re    = DW'($urandom);
      s_im    = DW'($urandom);
      tick();
      checks++;
      if ({dut_st(), dut_x()} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_state cyc=%0d got st=%h x=%h want all zero", c, dut_st(), dut_x());
      end
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1 || dut_st() !== mdl_st()) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got ready=%b st=%h want ready=1 st=%h", s_ready, dut_st(), mdl_st());
    end
  endtask

  task automatic test_single_frame();
    int fv_at [$];
    int fft_at [$];
    int xr [4];
    int xi [4];
    int yr [4];
    int yi [4];
    do_reset(2);
    last_frame.delete();
    for (int k = 1; k <= 4; k++) begin
      stim.push_back('{v: 1'b1, re: DW'(k), im: '0, last: (k == 4)});
      last_frame.push_back('{v: 1'b1, re: DW'(k), im: '0, last: (k == 4)});
    end
    add_idle(5);
    foreach (stim[i]) begin
      drive(stim[i]);
      tick();
      checks++;
      if (dut_st() !== mdl_st()) begin
        errors++;
        $display("[TB] FAIL single_status i=%0d got=%h want=%h", i, dut_st(), mdl_st());
      end
      if (frame_valid) fv_at.push_back(i);
      if (fft_valid) fft_at.push_back(i);
    end
    s_valid = 1'b0;
    checks++;
    if (fv_at.size() != 1 || fft_at.size() != 1 || fv_at[0] != 3 || fft_at[0] != 3 + L) begin
      errors++;
      $display("[TB] FAIL single_strobes got fv=%0d fft=%0d pulses want fv at 3, fft at %0d", fv_at.size(), fft_at.size(), 3 + L);
    end
    checks++;
    if (dut_x() !== stim_x() || frame_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL single_frame got x=%h cnt=%0d want x=%h cnt=1", dut_x(), frame_cnt, stim_x());
    end
    for (int k = 0; k < 4; k++) begin
      xr[k] = int'($signed(xo[2*k]));
      xi[k] = int'($signed(xo[2*k+1]));
    end
    yr[0] = xr[0] + xr[1] + xr[2] + xr[3];  yi[0] = xi[0] + xi[1] + xi[2] + xi[3];
    yr[1] = xr[0] + xi[1] - xr[2] - xi[3];  yi[1] = xi[0] - xr[1] - xi[2] + xr[3];
    yr[2] = xr[0] - xr[1] + xr[2] - xr[3];  yi[2] = xi[0] - xi[1] + xi[2] - xi[3];
    yr[3] = xr[0] - xi[1] - xr[2] + xi[3];  yi[3] = xi[0] + xr[1] - xi[2] - xr[3];
    checks++;
    if (yr[0] != 10 || yi[0] != 0 || yr[1] != -2 || yi[1] != 2 ||
        yr[2] != -2 || yi[2] != 0 || yr[3] != -2 || yi[3] != -2) begin
      errors++;
      $display("[TB] FAIL core_dft got y0=(%0d,%0d) y1=(%0d,%0d) y2=(%0d,%0d) y3=(%0d,%0d) want (10,0)(-2,2)(-2,0)(-2,-2)",
               yr[0], yi[0], yr[1], yi[1], yr[2], yi[2], yr[3], yi[3]);
    end
  endtask

  task automatic test_streaming();
    int fv_at [$];
    int fft_at [$];
    do_reset(1);
    for (int f = 0; f < 3; f++) add_frame(1'b1, 0);
    add_idle(4);
    foreach (stim[i]) begin
      drive(stim[i]);
      tick();
      checks++;
      if (dut_st() !== mdl_st() || dut_x() !== mdl_x()) begin
        errors++;
        $display("[TB] FAIL stream_status i=%0d got=%h want=%h", i, dut_st(), mdl_st());
      end
      if (frame_valid) fv_at.push_back(i + 1);
      if (fft_valid) fft_at.push_back(i + 1);
    end
    s_valid = 1'b0;
    checks++;
    if (fv_at.size() != 3 || fv_at[0] != 4 || fv_at[1] != 8 || fv_at[2] != 12) begin
      errors++;
      $display("[TB] FAIL stream_fv got %0d pulses first=%0d want 3 at 4,8,12", fv_at.size(), fv_at.size() ? fv_at[0] : -1);
    end
    checks++;
    if (fft_at.size() != 3 || fft_at[0] != 4 + L || fft_at[1] != 8 + L || fft_at[2] != 12 + L) begin
      errors++;
      $display("[TB] FAIL stream_fft got %0d pulses want 3 at %0d,%0d,%0d", fft_at.size(), 4 + L, 8 + L, 12 + L);
    end
    checks++;
    if (frame_cnt !== 16'd3 || dut_x() !== stim_x()) begin
      errors++;
      $display("[TB] FAIL stream_end got cnt=%0d x=%h want cnt=3 x=%h", frame_cnt, dut_x(), stim_x());
    end
  endtask

  task automatic test_gappy();
    int nfv = 0;
    do_reset(1);
    add_frame(1'b1, 5);
    add_idle(4);
    foreach (stim[i]) begin
      drive(stim[i]);
      tick();
      checks++;
      if (dut_st() !== mdl_st()) begin
        errors++;
        $display("[TB] FAIL gappy_status i=%0d got=%h want=%h", i, dut_st(), mdl_st());
      end
      if (frame_valid) nfv++;
    end
    s_valid = 1'b0;
    checks++;
    if (nfv != 1 || dut_x() !== stim_x() || frame_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL gappy_frame got fv=%0d x=%h cnt=%0d want fv=1 x=%h cnt=1", nfv, dut_x(), frame_cnt, stim_x());
    end
  endtask

  task automatic test_early_last();
    do_reset(1);
    stim.push_back('{v: 1'b1, re: DW'($urandom), im: DW'($urandom), last: 1'b0});
    stim.push_back('{v: 1'b1, re: DW'($urandom), im: DW'($urandom), last: 1'b1});
    add_frame(1'b1, 0);
    add_idle(3);
    foreach (stim[i]) begin
      drive(stim[i]);
      tick();
      checks++;
      if (dut_st() !== mdl_st()) begin
        errors++;
        $display("[TB] FAIL early_status i=%0d got=%h want=%h", i, dut_st(), mdl_st());
      end
    end
    s_valid = 1'b0;
    checks++;
    if (err_sticky !== 1'b1 || frame_cnt !== 16'd1 || dut_x() !== stim_x()) begin
      errors++;
      $display("[TB] FAIL early_frame got err=%b cnt=%0d x=%h want err=1 cnt=1 x=%h", err_sticky, frame_cnt, dut_x(), stim_x());
    end
    checks++;
    if (d0_err !== 1'b0 || d0_cnt !== 16'd1 || d0_cnt !== exp_cnt0) begin
      errors++;
      $display("[TB] FAIL early_nocheck got err=%b cnt=%0d want err=0 cnt=1", d0_err, d0_cnt);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b0 || dut_st() !== mdl_st()) begin
      errors++;
      $display("[TB] FAIL err_clr got err=%b want 0", err_sticky);
    end
  endtask

  task automatic test_missing_last();
    do_reset(1);
    add_frame(1'b0, 1);
    add_idle(3);
    foreach (stim[i]) begin
      drive(stim[i]);
      tick();
      checks++;
      if (dut_st() !== mdl_st()) begin
        errors++;
        $display("[TB] FAIL missing_status i=%0d got=%h want=%h", i, dut_st(), mdl_st());
      end
    end
    s_valid = 1'b0;
    checks++;
    if (err_sticky !== 1'b1 || frame_cnt !== 16'd1 || dut_x() !== stim_x()) begin
      errors++;
      $display("[TB] FAIL missing_frame got err=%b cnt=%0d x=%h want err=1 cnt=1 x=%h", err_sticky, frame_cnt, dut_x(), stim_x());
    end
    checks++;
    if (d0_err !== 1'b0 || d0_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL missing_nocheck got err=%b cnt=%0d want err=0 cnt=1", d0_err, d0_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int nfft = 0;
    do_reset(1);
    add_frame(1'b1, 0);
    stim.push_back('{v: 1'b1, re: DW'($urandom), im: DW'($urandom), last: 1'b0});
    stim.push_back('{v: 1'b1, re: DW'($urandom), im: DW'($urandom), last: 1'b0});
    foreach (stim[i]) begin
      drive(stim[i]);
      tick();
      checks++;
      if (dut_st() !== mdl_st()) begin
        errors++;
        $display("[TB] FAIL mid_status i=%0d got=%h want=%h", i, dut_st(), mdl_st());
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({dut_st(), dut_x()} !== '0) begin
        errors++;
        $display("[TB] FAIL mid_reset_zero c=%0d got st=%h x=%h want all zero", c, dut_st(), dut_x());
      end
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    tick();
    stim.delete();
    add_frame(1'b1, 0);
    foreach (stim[i]) begin
      drive(stim[i]);
      tick();
    end
    // The clean frame is visible now; reset hits the very next edge.
    checks++;
    if (frame_valid !== 1'b1 || dut_x() !== stim_x() || frame_cnt !== 16'd1 || err_sticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_frame got fv=%b x=%h cnt=%0d err=%b want fv=1 x=%h cnt=1 err=0",
               frame_valid, dut_x(), frame_cnt, err_sticky, stim_x());
    end
    reset   = 1'b1;
    s_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2 * L + 2; c++) begin
      tick();
      if (fft_valid) nfft++;
      checks++;
      if (dut_st() !== mdl_st()) begin
        errors++;
        $display("[TB] FAIL cancel_status c=%0d got=%h want=%h", c, dut_st(), mdl_st());
      end
    end
    checks++;
    if (nfft != 0) begin
      errors++;
      $display("[TB] FAIL fft_cancel got %0d fft_valid pulses want 0", nfft);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_streaming();
    test_gappy();
    test_early_last();
    test_missing_last();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
